mem_arbiter: RTL

Two-port to one-port memory arbiter that merges the Core's instruction bus (prefetch reads) and data bus (LoadStore reads/writes) onto a single external memory port. The Core uses it when the system has one unified memory. Data accesses have fixed priority. A starvation counter guarantees prefetch progress. Transactions are non-overlapping: one grant is held from access until ack.

---
 rtl/mem_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Merges the prefetch (instruction) and LoadStore (data) buses onto one memory port.
// Data wins arbitration unless the instruction port has been passed over INSTR_STARVE_LIMIT times.
module mem_arbiter #(
  parameter int unsigned INSTR_STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:1] instr_m_addr,
  output logic [15:0] instr_m_data_in,
  input  logic        instr_m_access,
  output logic        instr_m_ack,
  input  logic [19:1] data_m_addr,
  output logic [15:0] data_m_data_in,
  input  logic [15:0] data_m_data_out,
  input  logic        data_m_access,
  output logic        data_m_ack,
  input  logic        data_m_wr_en,
  input  logic [1:0]  data_m_bytesel,
  output logic [19:1] q_m_addr,
  input  logic [15:0] q_m_data_in,
  output logic [15:0] q_m_data_out,
  output logic        q_m_access,
  input  logic        q_m_ack,
  output logic        q_m_wr_en,
  output logic [1:0]  q_m_bytesel
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    GRANT_INSTR = 2'd1,
    GRANT_DATA  = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_LIMIT = 4'(INSTR_STARVE_LIMIT);

  state_t     state_r;
  state_t     state_next_s;
  logic [3:0] starve_cnt_r;
  logic [3:0] starve_cnt_next_s;

  // State and starvation counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      starve_cnt_r <= 4'd0;
    end else begin
      state_r      <= state_next_s;
      starve_cnt_r <= starve_cnt_next_s;
    end
  end

  // Arbitration in IDLE; a grant ends on ack or when its requester withdraws
  always_comb begin
    state_next_s      = state_r;
    starve_cnt_next_s = starve_cnt_r;
    case (state_r)
      IDLE: begin
        if (data_m_access && (!instr_m_access || (starve_cnt_r < STARVE_LIMIT))) begin
          state_next_s = GRANT_DATA;
        end else if (instr_m_access) begin
          state_next_s = GRANT_INSTR;
        end else begin
          state_next_s = IDLE;
        end
        if (!instr_m_access || (state_next_s == GRANT_INSTR)) begin
          starve_cnt_next_s = 4'd0;
        end else if (state_next_s == GRANT_DATA) begin
          starve_cnt_next_s = (starve_cnt_r == 4'd15) ? 4'd15 : starve_cnt_r + 4'd1;
        end else begin
          starve_cnt_next_s = starve_cnt_r;
        end
      end
      GRANT_INSTR: begin
        if (q_m_ack || !instr_m_access) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = GRANT_INSTR;
        end
      end
      GRANT_DATA: begin
        if (q_m_ack || !data_m_access) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = GRANT_DATA;
        end
      end
      default: begin
        state_next_s      = IDLE;
        starve_cnt_next_s = 4'd0;
      end
    endcase
  end

  // Shared-port steering and ack routing from the current grant
  always_comb begin
    q_m_access   = 1'b0;
    q_m_addr     = 19'd0;
    q_m_data_out = 16'd0;
    q_m_wr_en    = 1'b0;
    q_m_bytesel  = 2'b00;
    instr_m_ack  = 1'b0;
    data_m_ack   = 1'b0;
    case (state_r)
      GRANT_INSTR: begin
        q_m_access  = instr_m_access;
        q_m_addr    = instr_m_addr;
        q_m_bytesel = 2'b11;
        instr_m_ack = q_m_ack;
      end
      GRANT_DATA: begin
        q_m_access   = data_m_access;
        q_m_addr     = data_m_addr;
        q_m_data_out = data_m_data_out;
        q_m_wr_en    = data_m_wr_en;
        q_m_bytesel  = data_m_bytesel;
        data_m_ack   = q_m_ack;
      end
      IDLE: begin
        q_m_access = 1'b0;
      end
      default: begin
        q_m_access = 1'b0;
      end
    endcase
  end

  assign instr_m_data_in = q_m_data_in;
  assign data_m_data_in  = q_m_data_in;

endmodule
